htc_weight_bank_stream: RTL and testbench
=========================================

// Module: htc_weight_bank_stream
// PURPOSE
// Next-generation banked attractor-weight store for the HTC CAM core. It holds R rows of D bits in ROW_PAR banks.
// An internal sequencer sweeps a programmable range of row groups in row-major or chunk-major order.
// Beats stream out on a valid/ready interface with a credit-protected output FIFO.
// Plasticity writes and serialised bulk loads share the single memory write port through fixed-priority arbitration.
// PARAMETERS
// D          16384  hypervector width (bits)
// R          2048   attractor rows
// C          512    chunk width (bits); N_CHUNKS=D/C
// ROW_PAR    64     rows per beat (banks); R_GROUPS=R/ROW_PAR
// CHUNK_PAR  4      chunks per row per beat; C_GROUPS=N_CHUNKS/CHUNK_PAR
// OUT_DEPTH  4      output FIFO depth (>=3)
// PORTS
// clk             in   1                    clock
// rst_n           in   1                    async active-low reset
// sweep_start     in   1                    start sweep (ignored while sweep_busy)
// sweep_order     in   1                    0=row-major (cg inner), 1=chunk-major (rg inner); sampled at start
// sweep_rg_base   in   clog2(R_GROUPS)      first row group; sampled at start
// sweep_rg_count  in   clog2(R_GROUPS)+1    row groups to sweep, 0..R_GROUPS; sampled at start
// sweep_busy      out  1                    sweep active or FIFO not drained
// sweep_done      out  1                    1-cycle pulse at sweep end
// out_valid       out  1                    beat available
// out_ready       in   1                    consumer accepts beat
// out_data        out  [C*CHUNK_PAR] x ROW_PAR  bank b carries row rg*ROW_PAR+b, chunks cg*CHUNK_PAR+k at [k*C+:C]
// out_row_group   out  clog2(R_GROUPS)      rg of beat
// out_chunk_group out  clog2(C_GROUPS)      cg of beat
// out_last        out  1                    final beat of sweep
// wr_valid        in   1                    plasticity chunk write
// wr_ready        out  1                    always 1 (top write priority)
// wr_row          in   clog2(R)             target row
// wr_chunk        in   clog2(N_CHUNKS)      target chunk
// wr_data         in   C                    chunk data
// bulk_valid      in   1                    full-HV load request
// bulk_ready      out  1                    1 only in B_IDLE
// bulk_row        in   clog2(R)             target row
// bulk_hv         in   D                    HV, chunk ch at [ch*C+:C]
// BEHAVIOUR
// - Reset: all out_*, sweep_busy, sweep_done = 0; bulk_ready = 1; FIFO emptied; credits cleared. In-flight reads and bulk loads are abandoned. Memory contents are undefined.
// - Mapping: bank = row % ROW_PAR; address = (row/ROW_PAR)*N_CHUNKS + chunk.
// - Write port priority: wr > bulk chunk > sweep read issue. Any write in a cycle blocks sweep issue that cycle, so there are no same-cycle read/write collisions.
// - Bulk FSM B_IDLE->B_WRITE on bulk_valid&&bulk_ready; HV and row are latched.
//   - Each cycle without wr_valid writes chunk ch (0..N_CHUNKS-1) and increments ch.
//   - Returns to B_IDLE after chunk N_CHUNKS-1.
// - Sweep FSM S_IDLE->S_ISSUE on sweep_start. Counts are held in idx_rg (0..count-1) and cg. The issued row group is (base+idx_rg) mod R_GROUPS, so the range wraps.
//   - Row-major increments cg first. Chunk-major increments idx_rg first.
//   - Issue condition: no write this cycle AND fifo_count+inflight < OUT_DEPTH.
//   - Read latency is 2 cycles (address register, BRAM register), then FIFO push. A beat issued at cycle t is visible on out_* at t+3 if the FIFO is empty.
// - S_ISSUE->S_DRAIN after the last issue. S_DRAIN->S_DONE when inflight==0 and the FIFO is empty. S_DONE holds sweep_done=1 for one cycle, then returns to S_IDLE.
//   - sweep_busy is 1 in S_ISSUE, S_DRAIN and S_DONE.
// - sweep_rg_count==0: S_IDLE->S_DONE directly. sweep_done pulses 2 cycles after start; no beats are produced.
// - out_last is set on the beat for the final (rg,cg) issued.
// - FIFO handshake: pop on out_valid&&out_ready. Simultaneous push and pop on a full FIFO is legal. out_* stay stable while out_valid&&!out_ready.
// - Read-after-write: a write issued before a read's issue cycle is visible to that read.
// - sweep_start while busy is ignored. Bulk and plasticity writes during a sweep are allowed; they stall issue only.
// TESTING (bench params D=256 R=16 C=32 ROW_PAR=4 CHUNK_PAR=2 -> R_GROUPS=4 C_GROUPS=4)
// - Bulk-load rows 0..15 with row id replicated per chunk; sweep base=0 count=4 order=0, out_ready=1.
//   Required: 16 beats; (rg,cg) sequence (0,0),(0,1)..(3,3); bank b holds row 4rg+b; out_last only on beat 16; first out_valid at start+4.
// - order=1, base=3, count=2. Required: 8 beats; sequence (3,0),(0,0),(3,1),(0,1)..(0,3), showing wrap of rg 3->0.
// - out_ready held low for 20 cycles mid-sweep. Required: at most OUT_DEPTH beats buffered, no beat lost or duplicated, out_data stable while stalled.
// - wr_valid every other cycle during a sweep, writing row 5 chunk 2 = 0xDEADBEEF before row group 1 is issued.
//   Required: the beat (1,1) bank1 shows 0xDEADBEEF at [0+:32]; issue stalls only on write cycles.
// - count=0 -> no out_valid; sweep_done 2 cycles after start. A second sweep_start while busy is ignored.
// - rst_n asserted mid-sweep with 3 beats in flight. Required: out_valid=0, sweep_busy=0, bulk_ready=1 immediately; a fresh sweep afterwards behaves per scenario 1.

Source files
------------

// File: rtl/htc_weight_bank_stream.sv
// ----------------------------------------------------------------------------
// htc_weight_bank_stream
//
// Banked attractor-weight store for the HTC CAM core. R rows of D bits live in
// ROW_PAR banks (bank = row % ROW_PAR). An internal sequencer sweeps a
// programmable, wrapping range of row groups in row-major or chunk-major order.
// Each beat carries CHUNK_PAR chunks of ROW_PAR rows. Beats stream out through a
// credit-protected FIFO. Plasticity writes and serialised bulk loads share the
// single write port: plasticity has priority, then bulk, then sweep reads.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   sweep_start/order/rg_base/rg_count sweep request and its parameters
//   sweep_busy, sweep_done             sweep status, 1-cycle end pulse
//   out_valid/ready/data/row_group/chunk_group/last  beat stream
//   wr_valid/ready/row/chunk/data      plasticity chunk write (always ready)
//   bulk_valid/ready/row/hv            full hypervector load
//
// Bulk FSM
//   state   | meaning
//   B_IDLE  | ready to accept a bulk request
//   B_WRITE | writing latched HV one chunk per free write-port cycle
//
// Sweep FSM
//   state   | meaning
//   S_IDLE  | waiting for sweep_start
//   S_ISSUE | issuing reads when the write port is free and credits remain
//   S_DRAIN | all reads issued, waiting for pipeline and FIFO to empty
//   S_DONE  | sweep finished; sweep_done is raised on the following cycle
// ----------------------------------------------------------------------------
module htc_weight_bank_stream #(
  parameter int D         = 16384,
  parameter int R         = 2048,
  parameter int C         = 512,
  parameter int ROW_PAR   = 64,
  parameter int CHUNK_PAR = 4,
  parameter int OUT_DEPTH = 4,
  localparam int N_CHUNKS = D / C,
  localparam int R_GROUPS = R / ROW_PAR,
  localparam int C_GROUPS = N_CHUNKS / CHUNK_PAR,
  localparam int RG_W     = (R_GROUPS > 1) ? $clog2(R_GROUPS) : 1,
  localparam int CG_W     = (C_GROUPS > 1) ? $clog2(C_GROUPS) : 1,
  localparam int ROW_W    = (R > 1) ? $clog2(R) : 1,
  localparam int CH_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sweep_start,
  input  logic                                 sweep_order,
  input  logic [RG_W-1:0]                      sweep_rg_base,
  input  logic [RG_W:0]                        sweep_rg_count,
  output logic                                 sweep_busy,
  output logic                                 sweep_done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ROW_PAR-1:0][C*CHUNK_PAR-1:0]  out_data,
  output logic [RG_W-1:0]                      out_row_group,
  output logic [CG_W-1:0]                      out_chunk_group,
  output logic                                 out_last,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [ROW_W-1:0]                     wr_row,
  input  logic [CH_W-1:0]                      wr_chunk,
  input  logic [C-1:0]                         wr_data,
  input  logic                                 bulk_valid,
  output logic                                 bulk_ready,
  input  logic [ROW_W-1:0]                     bulk_row,
  input  logic [D-1:0]                         bulk_hv
);

  localparam int BANK_W = (ROW_PAR > 1) ? $clog2(ROW_PAR) : 1;
  localparam int SUB_W  = (CHUNK_PAR > 1) ? $clog2(CHUNK_PAR) : 1;
  localparam int DEPTH  = R_GROUPS * C_GROUPS;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  localparam logic [RG_W:0]    RG_LIM    = (RG_W+1)'(R_GROUPS);
  localparam logic [CG_W-1:0]  CG_LAST   = CG_W'(C_GROUPS - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CHUNKS - 1);
  localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W+1)'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(OUT_DEPTH - 1);

  typedef enum logic {B_IDLE, B_WRITE} bulk_state_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} sweep_state_t;

  bulk_state_t  b_state_q, b_state_d;
  sweep_state_t s_state_q, s_state_d;

  // bulk datapath
  logic [ROW_W-1:0] bulk_row_q;
  logic [D-1:0]     bulk_hv_q;
  logic [CH_W-1:0]  bulk_ch;
  logic             bulk_writing;
  logic             bulk_adv;

  // shared write port
  logic              mem_we;
  logic [ROW_W-1:0]  mem_row;
  logic [CH_W-1:0]   mem_chunk;
  logic [C-1:0]      mem_wdata;
  logic [BANK_W-1:0] wr_bank;
  logic [SUB_W-1:0]  wr_sub;
  logic [AW-1:0]     wr_addr;

  // sweep sequencer
  logic              order_q;
  logic [RG_W-1:0]   base_q;
  logic [RG_W:0]     count_q;
  logic [RG_W-1:0]   idx_rg;
  logic [CG_W-1:0]   cg_q;
  logic [RG_W:0]     rg_sum;
  logic [RG_W-1:0]   issue_rg;
  logic              idx_last;
  logic              last_issue;
  logic              issue;
  logic              done_d;
  logic [CNT_W:0]    occupancy;

  // read pipeline
  logic              rd_v1, rd_v2;
  logic [AW-1:0]     rd_addr;
  logic [RG_W-1:0]   s1_rg, s2_rg;
  logic [CG_W-1:0]   s1_cg, s2_cg;
  logic              s1_last, s2_last;
  logic [1:0]        inflight;
  logic [ROW_PAR-1:0][C*CHUNK_PAR-1:0] rd_word;

  // output FIFO
  logic [ROW_PAR-1:0][C*CHUNK_PAR-1:0] fifo_data [OUT_DEPTH];
  logic [RG_W-1:0]   fifo_rg   [OUT_DEPTH];
  logic [CG_W-1:0]   fifo_cg   [OUT_DEPTH];
  logic              fifo_last [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop;

  assign wr_ready = 1'b1;

  // --------------------------------------------------------------------------
  // Bulk FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_state_q <= B_IDLE;
    else        b_state_q <= b_state_d;
  end

  always_comb begin
    b_state_d = b_state_q;
    case (b_state_q)
      B_IDLE:  if (bulk_valid) b_state_d = B_WRITE;
      B_WRITE: if (bulk_adv && bulk_ch == CH_LAST) b_state_d = B_IDLE;
      default: b_state_d = B_IDLE;
    endcase
  end

  always_comb begin
    bulk_ready   = (b_state_q == B_IDLE);
    bulk_writing = (b_state_q == B_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bulk_ch <= '0;
    end else if (bulk_ready && bulk_valid) begin
      bulk_ch <= '0;
    end else if (bulk_adv) begin
      bulk_ch <= bulk_ch + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bulk_ready && bulk_valid) begin
      bulk_row_q <= bulk_row;
      bulk_hv_q  <= bulk_hv;
    end
  end

  // --------------------------------------------------------------------------
  // Write-port arbitration: plasticity, then bulk. Sweep issue sees mem_we.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_row   = '0;
    mem_chunk = '0;
    mem_wdata = '0;
    bulk_adv  = 1'b0;
    if (wr_valid) begin
      mem_we    = 1'b1;
      mem_row   = wr_row;
      mem_chunk = wr_chunk;
      mem_wdata = wr_data;
    end else if (bulk_writing) begin
      mem_we    = 1'b1;
      mem_row   = bulk_row_q;
      mem_chunk = bulk_ch;
      mem_wdata = bulk_hv_q[int'(bulk_ch)*C +: C];
      bulk_adv  = 1'b1;
    end
  end

  // Each bank is split into CHUNK_PAR sub-banks by chunk % CHUNK_PAR so one
  // beat reads CHUNK_PAR adjacent chunks at a single sub-bank address. This is
  // the row-group*N_CHUNKS+chunk layout with the low chunk bits peeled off.
  always_comb begin
    wr_bank = BANK_W'(mem_row % ROW_PAR);
    wr_sub  = SUB_W'(mem_chunk % CHUNK_PAR);
    wr_addr = AW'((mem_row / ROW_PAR) * C_GROUPS + (mem_chunk / CHUNK_PAR));
  end

  // --------------------------------------------------------------------------
  // Sweep FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_state_q <= S_IDLE;
    else        s_state_q <= s_state_d;
  end

  always_comb begin
    s_state_d = s_state_q;
    case (s_state_q)
      S_IDLE:  if (sweep_start) s_state_d = (sweep_rg_count == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (issue && last_issue) s_state_d = S_DRAIN;
      S_DRAIN: if (inflight == 2'd0 && fifo_count == '0) s_state_d = S_DONE;
      S_DONE:  s_state_d = S_IDLE;
      default: s_state_d = S_IDLE;
    endcase
  end

  // Credit check counts beats already in the FIFO plus those still in the
  // two read stages, so a push can never find the FIFO full.
  always_comb begin
    occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
    sweep_busy = (s_state_q != S_IDLE);
    issue      = (s_state_q == S_ISSUE) && !mem_we && (occupancy < DEPTH_LIM);
    done_d     = (s_state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sweep_done <= 1'b0;
    else        sweep_done <= done_d;
  end

  always_comb begin
    rg_sum = {1'b0, base_q} + {1'b0, idx_rg};
    if (rg_sum >= RG_LIM) rg_sum = rg_sum - RG_LIM;
    issue_rg   = rg_sum[RG_W-1:0];
    idx_last   = ({1'b0, idx_rg} == count_q - 1'b1);
    last_issue = idx_last && (cg_q == CG_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
      idx_rg  <= '0;
      cg_q    <= '0;
    end else if (s_state_q == S_IDLE && sweep_start) begin
      order_q <= sweep_order;
      base_q  <= sweep_rg_base;
      count_q <= sweep_rg_count;
      idx_rg  <= '0;
      cg_q    <= '0;
    end else if (issue && !last_issue) begin
      if (!order_q) begin
        if (cg_q == CG_LAST) begin
          cg_q   <= '0;
          idx_rg <= idx_rg + 1'b1;
        end else begin
          cg_q <= cg_q + 1'b1;
        end
      end else begin
        if (idx_last) begin
          idx_rg <= '0;
          cg_q   <= cg_q + 1'b1;
        end else begin
          idx_rg <= idx_rg + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline: address register, then RAM output register, then FIFO.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      rd_addr <= '0;
      s1_rg   <= '0;
      s1_cg   <= '0;
      s1_last <= 1'b0;
      s2_rg   <= '0;
      s2_cg   <= '0;
      s2_last <= 1'b0;
    end else begin
      rd_v1 <= issue;
      rd_v2 <= rd_v1;
      if (issue) begin
        rd_addr <= AW'(int'(issue_rg) * C_GROUPS + int'(cg_q));
        s1_rg   <= issue_rg;
        s1_cg   <= cg_q;
        s1_last <= last_issue;
      end
      if (rd_v1) begin
        s2_rg   <= s1_rg;
        s2_cg   <= s1_cg;
        s2_last <= s1_last;
      end
    end
  end

  assign inflight = {1'b0, rd_v1} + {1'b0, rd_v2};

  for (genvar b = 0; b < ROW_PAR; b++) begin : g_bank
    for (genvar k = 0; k < CHUNK_PAR; k++) begin : g_sub
      logic [C-1:0] ram [DEPTH];
      logic [C-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (mem_we && wr_bank == BANK_W'(b) && wr_sub == SUB_W'(k))
          ram[wr_addr] <= mem_wdata;
        if (rd_v1)
          rd_q <= ram[rd_addr];
      end
      assign rd_word[b][k*C +: C] = rd_q;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign push = rd_v2;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_word;
      fifo_rg[wr_ptr]   <= s2_rg;
      fifo_cg[wr_ptr]   <= s2_cg;
      fifo_last[wr_ptr] <= s2_last;
    end
  end

  // Storage is not reset, so the head is masked to keep out_* at zero while empty.
  always_comb begin
    out_valid       = (fifo_count != '0);
    out_data        = '0;
    out_row_group   = '0;
    out_chunk_group = '0;
    out_last        = 1'b0;
    if (out_valid) begin
      out_data        = fifo_data[rd_ptr];
      out_row_group   = fifo_rg[rd_ptr];
      out_chunk_group = fifo_cg[rd_ptr];
      out_last        = fifo_last[rd_ptr];
    end
  end

endmodule

// File: tb/tb_htc_weight_bank_stream.sv
module tb_htc_weight_bank_stream;

  localparam int D = 256, R = 16, C = 32, ROW_PAR = 4, CHUNK_PAR = 2, OUT_DEPTH = 4;
  localparam int NCH = D / C;          // 8
  localparam int RG = R / ROW_PAR;     // 4
  localparam int CGN = NCH / CHUNK_PAR; // 4

  logic clk = 1'b0;
  logic rst_n;
  logic sweep_start, sweep_order;
  logic [1:0] sweep_rg_base;
  logic [2:0] sweep_rg_count;
  logic sweep_busy, sweep_done;
  logic out_valid, out_ready;
  logic [ROW_PAR-1:0][C*CHUNK_PAR-1:0] out_data;
  logic [1:0] out_row_group, out_chunk_group;
  logic out_last;
  logic wr_valid, wr_ready;
  logic [3:0] wr_row;
  logic [2:0] wr_chunk;
  logic [31:0] wr_data;
  logic bulk_valid, bulk_ready;
  logic [3:0] bulk_row;
  logic [255:0] bulk_hv;

  int total = 0;
  int bad = 0;

  logic [31:0] model_mem [R][NCH];

  typedef struct packed {
    logic [1:0]   rg;
    logic [1:0]   cg;
    logic         last;
    logic [255:0] data;
  } beat_t;

  htc_weight_bank_stream #(
    .D(D), .R(R), .C(C), .ROW_PAR(ROW_PAR), .CHUNK_PAR(CHUNK_PAR), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sweep_start(sweep_start), .sweep_order(sweep_order),
    .sweep_rg_base(sweep_rg_base), .sweep_rg_count(sweep_rg_count),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_group(out_row_group), .out_chunk_group(out_chunk_group), .out_last(out_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_chunk(wr_chunk), .wr_data(wr_data),
    .bulk_valid(bulk_valid), .bulk_ready(bulk_ready), .bulk_row(bulk_row), .bulk_hv(bulk_hv)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bulk_wait_idle();
    int w;
    w = 0;
    while (bulk_ready !== 1'b1 && w < 40) begin
      cyc();
      w++;
    end
    chk("bulk_ready_wait", bulk_ready, 1);
  endtask

  task automatic bulk_load(input int row, input logic [255:0] hv);
    bulk_wait_idle();
    bulk_valid = 1'b1;
    bulk_row   = row[3:0];
    bulk_hv    = hv;
    cyc();
    bulk_valid = 1'b0;
    for (int ch = 0; ch < NCH; ch++) model_mem[row][ch] = hv[ch*C +: C];
  endtask

  task automatic load_row_ids();
    logic [255:0] hv;
    for (int r = 0; r < R; r++) begin
      for (int ch = 0; ch < NCH; ch++) hv[ch*C +: C] = 32'(r);
      bulk_load(r, hv);
    end
    bulk_wait_idle();
  endtask

  // rmode: 0 always ready, 1 ready low for 20 cycles from stall_at, 2 random ready
  task automatic run_sweep(input int base, input int cnt, input int order, input int rmode,
                           input int stall_at, input int wr_mode, input int restart_at,
                           input int exp_first, input int exp_last, input int exp_done);
    beat_t exp_q[$];
    beat_t e;
    int n, first_c, last_c, done_c, nbeats, exp_total;
    logic prev_stall;
    logic [255:0] held_d;
    logic [4:0] held_t;

    if (wr_mode != 0) model_mem[5][2] = 32'hDEADBEEF;

    for (int o = 0; o < cnt * CGN; o++) begin
      int i, g, rgv;
      if (order == 0) begin i = o / CGN; g = o % CGN; end
      else            begin i = o % cnt; g = o / cnt; end
      rgv = (base + i) % RG;
      e.rg = rgv[1:0];
      e.cg = g[1:0];
      e.last = (o == cnt * CGN - 1);
      for (int b = 0; b < ROW_PAR; b++)
        for (int k = 0; k < CHUNK_PAR; k++)
          e.data[b*64 + k*C +: C] = model_mem[rgv*ROW_PAR + b][g*CHUNK_PAR + k];
      exp_q.push_back(e);
    end
    exp_total = exp_q.size();

    n = 0; first_c = -1; last_c = -1; done_c = -1; nbeats = 0; prev_stall = 1'b0;
    held_d = '0; held_t = '0;
    while (n < 400 && done_c < 0) begin
      sweep_start = 1'b0;
      if (n == 0) begin
        sweep_start = 1'b1;
        sweep_rg_base = base[1:0];
        sweep_rg_count = cnt[2:0];
        sweep_order = order[0];
      end else if (n == restart_at) begin
        sweep_start = 1'b1;
        sweep_rg_base = 2'd1;
        sweep_rg_count = 3'd1;
        sweep_order = ~order[0];
      end
      case (rmode)
        1:       out_ready = !(n >= stall_at && n < stall_at + 20);
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
      wr_valid = (wr_mode != 0) && (n % 2 == 1);
      wr_row = 4'd5; wr_chunk = 3'd2; wr_data = 32'hDEADBEEF;

      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_d);
        chk("stall_tag", {out_row_group, out_chunk_group, out_last}, held_t);
      end
      if (out_valid && first_c < 0) first_c = n;
      if (out_valid && out_ready) begin
        nbeats++;
        if (out_last) last_c = n;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_rg", out_row_group, e.rg);
          chk("beat_cg", out_chunk_group, e.cg);
          chk("beat_last", out_last, e.last);
          chk("beat_data", out_data, e.data);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_t = {out_row_group, out_chunk_group, out_last};
      if (sweep_done) done_c = n;
      cyc();
      n++;
    end
    sweep_start = 1'b0;
    wr_valid = 1'b0;
    out_ready = 1'b1;

    chk("beat_count", nbeats, exp_total);
    chk("done_seen", (done_c >= 0), 1);
    chk("busy_after_done", sweep_busy, 0);
    if (exp_first >= 0) chk("first_valid_cycle", first_c, exp_first);
    if (exp_last >= 0)  chk("last_beat_cycle", last_c, exp_last);
    if (exp_done >= 0)  chk("done_cycle", done_c, exp_done);
  endtask

  initial begin
    int extra;
    logic [255:0] hv;

    rst_n = 1'b0;
    sweep_start = 1'b0; sweep_order = 1'b0; sweep_rg_base = '0; sweep_rg_count = '0;
    out_ready = 1'b0;
    wr_valid = 1'b0; wr_row = '0; wr_chunk = '0; wr_data = '0;
    bulk_valid = 1'b0; bulk_row = '0; bulk_hv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_bulk_ready", bulk_ready, 1);
    chk("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();

    // row-major full sweep, first beat at start+4, last at start+19
    load_row_ids();
    run_sweep(0, 4, 0, 0, 0, 0, -1, 4, 19, -1);

    // chunk-major wrapping range 3 -> 0, with an ignored restart while busy
    run_sweep(3, 2, 1, 0, 0, 0, 3, 4, 11, -1);

    // 20-cycle backpressure mid-sweep
    run_sweep(0, 4, 0, 1, 6, 0, -1, 4, -1, -1);

    // plasticity writes on odd cycles: issues land on even cycles only
    run_sweep(0, 4, 0, 0, 0, 1, -1, 5, 35, -1);

    // empty sweep, restart while in S_DONE ignored
    run_sweep(0, 0, 0, 0, 0, 0, 1, -1, -1, 2);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || sweep_done) extra++;
      cyc();
    end
    chk("zero_count_quiet", extra, 0);

    // reset with beats in flight
    sweep_rg_base = 2'd0; sweep_rg_count = 3'd4; sweep_order = 1'b0;
    out_ready = 1'b0;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", sweep_busy, 0);
    chk("mid_rst_bulk_ready", bulk_ready, 1);
    chk("mid_rst_done", sweep_done, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    load_row_ids();
    run_sweep(0, 4, 0, 0, 0, 0, -1, 4, 19, -1);

    // randomized contents, ranges, orders and backpressure
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 4; j++) begin
        for (int ch = 0; ch < NCH; ch++) hv[ch*C +: C] = $urandom;
        bulk_load($urandom_range(0, R - 1), hv);
      end
      bulk_wait_idle();
      run_sweep($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 1),
                2, 0, 0, -1, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
